// File: rtl/gsensor_pkg.sv
// rtl/gsensor_pkg.sv - register map, reset values and FSM states for the GSENSOR responder
package gsensor_pkg;

  localparam logic [5:0] DEVID_ADDR   = 6'h00;
  localparam logic [5:0] BW_RATE_ADDR = 6'h2C;
  localparam logic [5:0] DATAX0_ADDR  = 6'h32;
  localparam logic [5:0] DATAX1_ADDR  = 6'h33;
  localparam logic [5:0] DATAY0_ADDR  = 6'h34;
  localparam logic [5:0] DATAY1_ADDR  = 6'h35;
  localparam logic [5:0] DATAZ0_ADDR  = 6'h36;
  localparam logic [5:0] DATAZ1_ADDR  = 6'h37;

  localparam logic [7:0] BW_RATE_RST  = 8'h0A;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  function automatic logic reg_writable(input logic [5:0] a);
    return (a != DEVID_ADDR) && !((a >= DATAX0_ADDR) && (a <= DATAZ1_ADDR));
  endfunction

  function automatic logic [7:0] reg_reset(input logic [5:0] a, input logic [7:0] devid);
    if (a == DEVID_ADDR)   return devid;
    if (a == BW_RATE_ADDR) return BW_RATE_RST;
    return 8'h00;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizes SCLK/CS_N/SDI into the system clock and detects their edges
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic cs_rise,
  output logic cs_fall,
  output logic sdi_s
);

  logic [STAGES-1:0] sclk_q, sclk_d, cs_q, cs_d, sdi_q, sdi_d;
  logic              sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;

  always_comb begin
    sclk_d      = {sclk_q[STAGES-2:0], sclk};
    cs_d        = {cs_q[STAGES-2:0], cs_n};
    sdi_d       = {sdi_q[STAGES-2:0], sdi};
    sclk_prev_d = sclk_q[STAGES-1];
    cs_prev_d   = cs_q[STAGES-1];
  end

  // SCLK and CS_N idle high, so the chains reset high to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '1;
      cs_q        <= '1;
      sdi_q       <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      sdi_q       <= sdi_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_rise = sclk_q[STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[STAGES-1] & sclk_prev_q;
  assign cs_n_s    = cs_q[STAGES-1];
  assign cs_rise   = cs_q[STAGES-1] & ~cs_prev_q;
  assign cs_fall   = ~cs_q[STAGES-1] & cs_prev_q;
  assign sdi_s     = sdi_q[STAGES-1];

endmodule

// File: rtl/gsensor_spi_responder.sv
// rtl/gsensor_spi_responder.sv - mode-3 SPI slave emulating an ADXL345-style accelerometer register file
module gsensor_spi_responder
  import gsensor_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        MAX10_CLK1_50,
  input  logic        RST,
  input  logic        SPI_CS_N,
  input  logic        SPI_SCLK,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE,
  input  logic        SAMPLE_VALID,
  input  logic [15:0] SAMPLE_X,
  input  logic [15:0] SAMPLE_Y,
  input  logic [15:0] SAMPLE_Z,
  output logic        WR_STROBE,
  output logic [5:0]  WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        FRAME_ERR
);

  logic sclk_rise, sclk_fall, cs_n_s, cs_rise, cs_fall, sdi_s;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (MAX10_CLK1_50),
    .rst       (RST),
    .sclk      (SPI_SCLK),
    .cs_n      (SPI_CS_N),
    .sdi       (SPI_SDI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .sdi_s     (sdi_s)
  );

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic        rw_q, rw_d, mb_q, mb_d, byte_done_q, byte_done_d;
  logic [5:0]  addr_q, addr_d;
  logic        sdo_q, sdo_d, oe_q, oe_d;
  logic        wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        pend_q, pend_d;
  logic [47:0] pend_data_q, pend_data_d;
  logic [7:0]  regs_q [64];
  logic [7:0]  regs_d [64];

  logic [7:0]  rx_byte, rd_byte;
  logic        sample_we;
  logic [47:0] sample_word;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    mb_d        = mb_q;
    byte_done_d = byte_done_q;
    addr_d      = addr_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    regs_d      = regs_q;
    sample_we   = 1'b0;
    sample_word = pend_data_q;

    rx_byte = {rx_q[6:0], sdi_s};
    // With MB clear only the first data byte addresses the regfile.
    rd_byte = (mb_q || !byte_done_q) ? regs_q[addr_q] : 8'h00;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d        = rx_byte[7];
            mb_d        = rx_byte[6];
            addr_d      = rx_byte[5:0];
            byte_done_d = 1'b0;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if (sclk_fall && rw_q) begin
          oe_d = 1'b1;
          if (bit_cnt_q == 3'd0) begin
            sdo_d = rd_byte[7];
            tx_d  = {rd_byte[6:0], 1'b0};
          end else begin
            sdo_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rw_q && (mb_q || !byte_done_q) && reg_writable(addr_q)) begin
              regs_d[addr_q] = rx_byte;
              wr_strobe_d    = 1'b1;
              wr_addr_d      = addr_q;
              wr_data_d      = rx_byte;
            end
            byte_done_d = 1'b1;
            if (mb_q) addr_d = addr_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d     = IDLE;
      oe_d        = 1'b0;
      sdo_d       = 1'b0;
      bit_cnt_d   = 3'd0;
      frame_err_d = (state_q != IDLE) && (bit_cnt_q != 3'd0);
    end

    // Samples arriving mid-frame wait until CS_N is back high so a burst read stays coherent.
    if (SAMPLE_VALID) begin
      if (!cs_n_s) begin
        pend_d      = 1'b1;
        pend_data_d = {SAMPLE_Z, SAMPLE_Y, SAMPLE_X};
      end else begin
        sample_we   = 1'b1;
        sample_word = {SAMPLE_Z, SAMPLE_Y, SAMPLE_X};
        pend_d      = 1'b0;
      end
    end else if (pend_q && cs_n_s) begin
      sample_we = 1'b1;
      pend_d    = 1'b0;
    end

    if (sample_we) begin
      for (int i = 0; i < 6; i++) begin
        regs_d[6'(int'(DATAX0_ADDR) + i)] = sample_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      mb_q        <= 1'b0;
      byte_done_q <= 1'b0;
      addr_q      <= 6'd0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= 48'h0;
      for (int i = 0; i < 64; i++) regs_q[i] <= reg_reset(6'(i), DEVID);
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      mb_q        <= mb_d;
      byte_done_q <= byte_done_d;
      addr_q      <= addr_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      for (int i = 0; i < 64; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign SPI_SDO    = sdo_q;
  assign SPI_SDO_OE = oe_q;
  assign WR_STROBE  = wr_strobe_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

Behavioural SPI slave that plays the accelerometer end of the GSENSOR 4-wire SPI link (mode 3, ADXL345-style framing), so the FPGA-side SPI master can be exercised on the board or in simulation without the physical sensor. It holds a 64×8 register file, answers register reads and writes, and publishes X/Y/Z samples from a parallel source into the data registers. It is clocked from the 50 MHz board clock and oversamples the SPI pins.

## Interface
Parameters:
- DEVID, 8'hE5, read-only value at address 0x00
- SYNC_STAGES, 2, synchronizer depth on SCLK/CS_N/SDI (≥2)

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz
- RST  in  1  reset, asynchronous, active-high
- SPI_CS_N  in  1  chip select, active-low
- SPI_SCLK  in  1  SPI clock, idles high; max frequency MAX10_CLK1_50/8
- SPI_SDI  in  1  master-to-slave data
- SPI_SDO  out  1  slave-to-master data
- SPI_SDO_OE  out  1  SDO output enable (1 = drive)
- SAMPLE_VALID  in  1  single-cycle strobe; X/Y/Z valid
- SAMPLE_X, SAMPLE_Y, SAMPLE_Z  in  16 each  two's-complement samples
- WR_STROBE  out  1  one-cycle pulse per accepted SPI register write
- WR_ADDR  out  6  address of that write
- WR_DATA  out  8  data of that write
- FRAME_ERR  out  1  one-cycle pulse: CS_N rose mid-byte

## Operation
- SCLK, CS_N, SDI pass through SYNC_STAGES flops; rising/falling SCLK edges detected on synchronized signals.
- Frame: CS_N falls → state CMD. First byte MSB-first: bit7 R/W (1 = read), bit6 MB, bits5:0 start address. Bits captured on SCLK rising edges; bit counter 3 bits.
- CMD → DATA after 8th rising edge. Address register ← bits5:0.
- Read: SPI_SDO_OE = 1 from the first falling edge after byte 0 until CS_N rises. On each falling edge shift out next bit, MSB first; byte loaded from regfile[addr] at the falling edge that emits its MSB.
- Write: after each 8 data bits, if addr is writable, regfile[addr] ← byte and WR_STROBE/WR_ADDR/WR_DATA pulse one cycle later.
- MB = 1: addr increments after each data byte, 0x3F wraps to 0x00. MB = 0: only first data byte used; later write bytes discarded, later read bytes return 0x00.
- Read-only: 0x00 (DEVID) and 0x32–0x37; SPI writes there ignored, no WR_STROBE.
- Reset values: regfile 0x00 = DEVID, 0x2C = 0x0A, all others 0x00.
- SAMPLE_VALID: 0x32←X[7:0], 0x33←X[15:8], 0x34←Y[7:0], 0x35←Y[15:8], 0x36←Z[7:0], 0x37←Z[15:8]. If CS_N (synchronized) is low, sample is held in a pending buffer and committed the cycle after CS_N rises; a newer SAMPLE_VALID overwrites the pending buffer.
- CS_N rise any state → IDLE, SDO_OE = 0 same cycle. If bit counter ≠ 0: FRAME_ERR pulse; partial byte discarded (no write).
- CS_N low while in IDLE only on a falling edge of CS_N; SCLK edges with CS_N high ignored.

## Timing
- All outputs reset to 0; regfile to reset values; state IDLE; pending buffer empty.
- RST asynchronous mid-frame: all of the above immediately, SDO_OE = 0; regfile reset too.
- SCLK edge to SDO change: SYNC_STAGES + 1 clock cycles (≤60 ns at defaults), guaranteeing setup before next rising edge at ≤6.25 MHz.
- CS_N rise to SDO_OE = 0: SYNC_STAGES + 1 cycles.
- Write commit: regfile updated 1 cycle after 8th data rising edge detected; WR_STROBE same cycle as commit.
- SPI write and SAMPLE_VALID in the same cycle: cannot conflict (sample addresses read-only).

## Structure
- Package gsensor_pkg: register address constants (DEVID_ADDR, BW_RATE_ADDR, DATAX0_ADDR…DATAZ1_ADDR), reset values, state enum {IDLE, CMD, DATA}.
- Sub-module spi_in_sync: parameterized synchronizer plus rise/fall edge detect for SCLK, and sync for CS_N and SDI.

## Test plan
- Read 0x00, MB = 0 (byte 0x80, 8 dummy clocks) → SDO returns 0xE5; SDO_OE low after CS_N rise.
- Write 0x2D ← 0x08 (bytes 0x2D, 0x08) → WR_STROBE once, WR_ADDR = 0x2D, WR_DATA = 0x08; subsequent read returns 0x08.
- SAMPLE_VALID X = 0x1234, Y = 0xFFFE, Z = 0x0100 with CS_N high, then MB read from 0x32 (byte 0xF2) of 6 bytes → 34 12 FE FF 00 01.
- SAMPLE_VALID during active read of 0x32 → bytes in progress show old values; read after CS_N rise shows new values.
- MB write from 0x3F of 2 bytes (0x7F, 0xAA, 0x55) → writes 0x3F = 0xAA, then 0x00 ignored (read-only), exactly one WR_STROBE.
- CS_N raised after 5 data bits of a write → FRAME_ERR pulse, no WR_STROBE, register unchanged; RST mid-frame → SDO_OE = 0 immediately, 0x2C reads 0x0A.
